unaligned_banked_ram: RTL and testbench

- Dual-port, single-clock on-chip RAM with two independent ports.
- Port A serves the CPU/custom-instruction side:
  - byte-addressed reads and writes at any byte offset;
  - an unaligned access may span two consecutive entries and still completes in one issue slot, because even and odd words live in separate banks.
- Port B serves the DMA side: aligned, word-addressed accesses.
- Sits between the custom-instruction decoder and the DMA engine as the shared scratch memory.

---
 rtl/ram_pkg.sv | 52 +++++
 rtl/unaligned_banked_ram_ssram_bank.sv | 56 +++++
 rtl/unaligned_banked_ram.sv | 199 +++++++++++++++++++
 tb/tb_unaligned_banked_ram.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared definitions for the unaligned banked scratch RAM.
//   - Default geometry and the widest word the helpers support.
//   - map_byte: window byte k at offset o -> (which word, which lane).
//   - merge_window: builds the big-endian read window from the two words
//     that straddle it.
//   Byte lane 0 of a word is its most significant byte throughout.
package ram_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_WORD_BYTES    = 4;
  localparam int DEF_NR_OF_ENTRIES = 512;

  // The helpers work on vectors this wide; WORD_BYTES must stay below it.
  localparam int MAX_BYTES = 64;
  localparam int MAX_BITS  = BYTE_W * MAX_BYTES;

  // hi = 0: byte belongs to word w, hi = 1: byte belongs to word w+1.
  typedef struct packed {
    logic       hi;
    logic [7:0] lane;
  } lane_sel_t;

  function automatic lane_sel_t map_byte(input int unsigned k,
                                         input int unsigned o,
                                         input int unsigned wb);
    lane_sel_t   r;
    int unsigned pos;
    pos = o + k;
    if (pos >= wb) begin
      r.hi   = 1'b1;
      r.lane = 8'(pos - wb);
    end else begin
      r.hi   = 1'b0;
      r.lane = 8'(pos);
    end
    return r;
  endfunction

  // Concatenate {lo, hi} as 2*wb contiguous bytes and shift so that byte o
  // of lo lands in the top lane of the returned word. Only the low wb bytes
  // of the result are meaningful; callers truncate.
  function automatic logic [MAX_BITS-1:0] merge_window(input logic [MAX_BITS-1:0] lo_word,
                                                       input logic [MAX_BITS-1:0] hi_word,
                                                       input int unsigned         o,
                                                       input int unsigned         wb);
    logic [2*MAX_BITS-1:0] pair;
    pair = ((2*MAX_BITS)'(lo_word) << (BYTE_W * wb)) | (2*MAX_BITS)'(hi_word);
    return MAX_BITS'(pair >> (BYTE_W * (wb - o)));
  endfunction

endpackage

// File: rtl/unaligned_banked_ram_ssram_bank.sv
// ssram_bank
//   True-dual-port synchronous RAM, one clock, per-byte write enables,
//   read-first, registered read data. Contents are never reset; only the
//   read-data registers clear on reset.
// Ports:
//   clock, reset                  clock / synchronous active-high reset
//   enableA/B                     port access strobe (read data updates)
//   writeEnableA/B [BYTES]        bit l writes byte lane l (lane 0 = MSB)
//   addressA/B                    row address
//   dataInA/B, dataOutA/B         write data / registered read data
// Same-edge writes to one byte from both ports: port A wins.
module ssram_bank
  import ram_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enableA,
  input  logic [BYTES-1:0]           writeEnableA,
  input  logic [$clog2(DEPTH)-1:0]   addressA,
  input  logic [BYTE_W*BYTES-1:0]    dataInA,
  output logic [BYTE_W*BYTES-1:0]    dataOutA,
  input  logic                       enableB,
  input  logic [BYTES-1:0]           writeEnableB,
  input  logic [$clog2(DEPTH)-1:0]   addressB,
  input  logic [BYTE_W*BYTES-1:0]    dataInB,
  output logic [BYTE_W*BYTES-1:0]    dataOutB
);

  logic [BYTE_W*BYTES-1:0] mem [DEPTH];

  // Port B is applied first so port A's nonblocking update to the same
  // byte lands last and wins.
  always_ff @(posedge clock) begin
    for (int l = 0; l < BYTES; l++) begin
      if (enableB && writeEnableB[l])
        mem[addressB][BYTE_W*(BYTES-1-l) +: BYTE_W] <= dataInB[BYTE_W*(BYTES-1-l) +: BYTE_W];
      if (enableA && writeEnableA[l])
        mem[addressA][BYTE_W*(BYTES-1-l) +: BYTE_W] <= dataInA[BYTE_W*(BYTES-1-l) +: BYTE_W];
    end
  end

  // Read-first: the nonblocking read samples the pre-write contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataOutA <= '0;
      dataOutB <= '0;
    end else begin
      if (enableA) dataOutA <= mem[addressA];
      if (enableB) dataOutB <= mem[addressB];
    end
  end

endmodule

// File: rtl/unaligned_banked_ram.sv
// unaligned_banked_ram
//   Dual-port scratch RAM shared by the custom-instruction decoder (port A)
//   and the DMA engine (port B). Even words live in one bank and odd words
//   in the other, so a port-A window straddling two words touches each bank
//   once and completes in a single issue slot.
// Ports:
//   clock, reset                       clock / synchronous active-high reset
//   requestA, writeEnableA             port A strobe, 1 = write
//   addressA [WADDR_W+OFF_W]           byte address of window start
//   byteEnableA [WORD_BYTES]           window byte k enabled by bit WORD_BYTES-1-k
//   dataInA, dataOutA, validA          big-endian window data, read valid
//   requestB, writeEnableB             port B strobe, 1 = write
//   addressB [WADDR_W]                 word address
//   dataInB, dataOutB, validB          word data, read valid
// Handshake: a request is taken every cycle its strobe is high and reset is
//   low; there is no ready/backpressure. A port-A read returns with validA
//   two cycles later, a port-B read with validB one cycle later; writes never
//   raise valid. Reset drops every read in flight.
module unaligned_banked_ram
  import ram_pkg::*;
#(
  parameter  int WORD_BYTES    = DEF_WORD_BYTES,
  parameter  int NR_OF_ENTRIES = DEF_NR_OF_ENTRIES,
  localparam int BITWIDTH      = BYTE_W * WORD_BYTES,
  localparam int OFF_W         = $clog2(WORD_BYTES),
  localparam int WADDR_W       = $clog2(NR_OF_ENTRIES),
  localparam int ROWS          = NR_OF_ENTRIES / 2,
  localparam int ROW_W         = WADDR_W - 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     requestA,
  input  logic                     writeEnableA,
  input  logic [WADDR_W+OFF_W-1:0] addressA,
  input  logic [WORD_BYTES-1:0]    byteEnableA,
  input  logic [BITWIDTH-1:0]      dataInA,
  output logic [BITWIDTH-1:0]      dataOutA,
  output logic                     validA,
  input  logic                     requestB,
  input  logic                     writeEnableB,
  input  logic [WADDR_W-1:0]       addressB,
  input  logic [BITWIDTH-1:0]      dataInB,
  output logic [BITWIDTH-1:0]      dataOutB,
  output logic                     validB
);

  // Requests seen while reset is high are ignored, writes included.
  logic a_fire;
  logic b_fire;
  assign a_fire = requestA & ~reset;
  assign b_fire = requestB & ~reset;

  // ---------------------------------------------------------------- port A
  logic [WADDR_W-1:0] word_a;
  logic [OFF_W-1:0]   off_a;
  logic               word_odd_a;
  logic [ROW_W-1:0]   row_a;
  logic [ROW_W-1:0]   row_next_a;
  logic [ROW_W-1:0]   even_row_a;

  assign word_a     = addressA[WADDR_W+OFF_W-1:OFF_W];
  assign off_a      = addressA[OFF_W-1:0];
  assign word_odd_a = word_a[0];
  assign row_a      = word_a[WADDR_W-1:1];
  // Wraps naturally at ROWS, which carries word NR_OF_ENTRIES-1 into word 0.
  assign row_next_a = row_a + ROW_W'(1);
  // Odd w: word w+1 is even and sits one row further down the even bank.
  assign even_row_a = word_odd_a ? row_next_a : row_a;

  // Write steering: each enabled window byte goes to the bank holding its
  // word (w, or w+1 past the end of word w) at the lane map_byte names.
  // With offset 0 no byte maps to w+1, so the second bank sees no enables.
  lane_sel_t             sel;
  logic [WORD_BYTES-1:0] we_even;
  logic [WORD_BYTES-1:0] we_odd;
  logic [BITWIDTH-1:0]   wd_even;
  logic [BITWIDTH-1:0]   wd_odd;

  always_comb begin
    sel     = '0;
    we_even = '0;
    we_odd  = '0;
    wd_even = '0;
    wd_odd  = '0;
    if (a_fire && writeEnableA) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        sel = map_byte(k, 32'(off_a), WORD_BYTES);
        if (byteEnableA[WORD_BYTES-1-k]) begin
          for (int l = 0; l < WORD_BYTES; l++) begin
            if (sel.lane == 8'(l)) begin
              if (word_odd_a ^ sel.hi) begin
                we_odd[l] = 1'b1;
                wd_odd[BYTE_W*(WORD_BYTES-1-l) +: BYTE_W] =
                  dataInA[BYTE_W*(WORD_BYTES-1-k) +: BYTE_W];
              end else begin
                we_even[l] = 1'b1;
                wd_even[BYTE_W*(WORD_BYTES-1-l) +: BYTE_W] =
                  dataInA[BYTE_W*(WORD_BYTES-1-k) +: BYTE_W];
              end
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- port B
  logic                  bank_b;
  logic [ROW_W-1:0]      row_b;
  logic [WORD_BYTES-1:0] we_b;

  assign bank_b = addressB[0];
  assign row_b  = addressB[WADDR_W-1:1];
  assign we_b   = {WORD_BYTES{writeEnableB}};

  // ----------------------------------------------------------------- banks
  logic [BITWIDTH-1:0] even_rd_a;
  logic [BITWIDTH-1:0] odd_rd_a;
  logic [BITWIDTH-1:0] even_rd_b;
  logic [BITWIDTH-1:0] odd_rd_b;

  ssram_bank #(.BYTES(WORD_BYTES), .DEPTH(ROWS)) u_even (
    .clock       (clock),
    .reset       (reset),
    .enableA     (a_fire),
    .writeEnableA(we_even),
    .addressA    (even_row_a),
    .dataInA     (wd_even),
    .dataOutA    (even_rd_a),
    .enableB     (b_fire & ~bank_b),
    .writeEnableB(we_b),
    .addressB    (row_b),
    .dataInB     (dataInB),
    .dataOutB    (even_rd_b)
  );

  ssram_bank #(.BYTES(WORD_BYTES), .DEPTH(ROWS)) u_odd (
    .clock       (clock),
    .reset       (reset),
    .enableA     (a_fire),
    .writeEnableA(we_odd),
    .addressA    (row_a),
    .dataInA     (wd_odd),
    .dataOutA    (odd_rd_a),
    .enableB     (b_fire & bank_b),
    .writeEnableB(we_b),
    .addressB    (row_b),
    .dataInB     (dataInB),
    .dataOutB    (odd_rd_b)
  );

  // ------------------------------------------------- read pipeline, port A
  // Stage 1 is the bank read; the offset and word parity ride alongside so
  // stage 2 knows which bank holds word w and how far to rotate.
  logic             rd1_valid;
  logic             rd1_odd;
  logic [OFF_W-1:0] rd1_off;
  logic [BITWIDTH-1:0] lo_word;
  logic [BITWIDTH-1:0] hi_word;

  assign lo_word = rd1_odd ? odd_rd_a  : even_rd_a;
  assign hi_word = rd1_odd ? even_rd_a : odd_rd_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd1_valid <= 1'b0;
      rd1_odd   <= 1'b0;
      rd1_off   <= '0;
      validA    <= 1'b0;
      dataOutA  <= '0;
    end else begin
      rd1_valid <= a_fire & ~writeEnableA;
      rd1_odd   <= word_odd_a;
      rd1_off   <= off_a;
      validA    <= rd1_valid;
      if (rd1_valid)
        dataOutA <= BITWIDTH'(merge_window(MAX_BITS'(lo_word), MAX_BITS'(hi_word),
                                           32'(rd1_off), WORD_BYTES));
    end
  end

  // ------------------------------------------------- read return, port B
  // The bank output register is the single latency stage; only the
  // addressed bank updated, so remember which one to present.
  logic bank_b_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      validB   <= 1'b0;
      bank_b_q <= 1'b0;
    end else begin
      validB <= b_fire & ~writeEnableB;
      if (b_fire) bank_b_q <= bank_b;
    end
  end

  assign dataOutB = bank_b_q ? odd_rd_b : even_rd_b;

endmodule

// File: tb/tb_unaligned_banked_ram.sv
// tb_unaligned_banked_ram
//   Directed and random stimulus for unaligned_banked_ram (4-byte words,
//   512 entries). A flat word-array model produces expected read data at
//   issue time; expectations and their due cycle go into queues and are
//   popped when validA / validB appear.
module tb_unaligned_banked_ram;

  localparam int WB = 4;
  localparam int NE = 512;
  localparam int BW = 8 * WB;

  // ------------------------------------------------ clock / reset / DUT
  logic          clock = 1'b0;
  logic          reset;
  logic          requestA, writeEnableA;
  logic [10:0]   addressA;
  logic [WB-1:0] byteEnableA;
  logic [BW-1:0] dataInA, dataOutA;
  logic          validA;
  logic          requestB, writeEnableB;
  logic [8:0]    addressB;
  logic [BW-1:0] dataInB, dataOutB;
  logic          validB;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  unaligned_banked_ram #(.WORD_BYTES(WB), .NR_OF_ENTRIES(NE)) dut (
    .clock       (clock),
    .reset       (reset),
    .requestA    (requestA),
    .writeEnableA(writeEnableA),
    .addressA    (addressA),
    .byteEnableA (byteEnableA),
    .dataInA     (dataInA),
    .dataOutA    (dataOutA),
    .validA      (validA),
    .requestB    (requestB),
    .writeEnableB(writeEnableB),
    .addressB    (addressB),
    .dataInB     (dataInB),
    .dataOutB    (dataOutB),
    .validB      (validB)
  );

  // ------------------------------------------------------- scoreboard
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [BW-1:0] model [NE];
  logic [BW-1:0] exp_a_q[$];
  logic [BW-1:0] exp_b_q[$];
  int            due_a_q[$];
  int            due_b_q[$];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_read(input logic [10:0] addr);
    int unsigned   w, o, pos, ln;
    logic [8:0]    wi;
    logic [7:0]    b;
    logic [BW-1:0] r;
    w = 32'(addr[10:2]);
    o = 32'(addr[1:0]);
    r = '0;
    for (int k = 0; k < WB; k++) begin
      pos = o + k;
      wi  = 9'(w + pos / WB);
      ln  = pos % WB;
      b   = 8'(model[wi] >> (8 * (WB - 1 - ln)));
      r   = r | (BW'(b) << (8 * (WB - 1 - k)));
    end
    return r;
  endfunction

  task automatic model_write_a(input logic [10:0] addr, input logic [WB-1:0] be, input logic [BW-1:0] din);
    int unsigned w, o, pos, ln;
    logic [8:0]  wi;
    logic [7:0]  b;
    w = 32'(addr[10:2]);
    o = 32'(addr[1:0]);
    for (int k = 0; k < WB; k++) begin
      if (((be >> (WB - 1 - k)) & 4'd1) != 4'd0) begin
        pos = o + k;
        wi  = 9'(w + pos / WB);
        ln  = pos % WB;
        b   = 8'(din >> (8 * (WB - 1 - k)));
        model[wi] = (model[wi] & ~(BW'(8'hFF) << (8 * (WB - 1 - ln)))) | (BW'(b) << (8 * (WB - 1 - ln)));
      end
    end
  endtask

  // Output monitor, sampled away from the rising edge.
  always @(negedge clock) begin
    if (validA) begin
      if (exp_a_q.size() > 0) begin
        check("read_a", dataOutA, exp_a_q.pop_front());
        check("latency_a", 32'(cyc), 32'(due_a_q.pop_front()));
      end else begin
        check("spurious_valid_a", 32'(validA), 32'd0);
      end
    end
    if (validB) begin
      if (exp_b_q.size() > 0) begin
        check("read_b", dataOutB, exp_b_q.pop_front());
        check("latency_b", 32'(cyc), 32'(due_b_q.pop_front()));
      end else begin
        check("spurious_valid_b", 32'(validB), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------- drivers
  // One issue slot per call. Read expectations are taken from the model
  // before this cycle's writes are applied (read-first), then B's write and
  // A's write land in that order so A wins overlapping bytes.
  task automatic issue(input logic ra, input logic wa, input logic [10:0] aa,
                       input logic [WB-1:0] be, input logic [BW-1:0] da,
                       input logic rb, input logic wb, input logic [8:0] ab,
                       input logic [BW-1:0] db,
                       input logic fa, input logic [BW-1:0] ea,
                       input logic fb, input logic [BW-1:0] eb);
    requestA = ra; writeEnableA = wa; addressA = aa; byteEnableA = be; dataInA = da;
    requestB = rb; writeEnableB = wb; addressB = ab; dataInB = db;
    if (ra && !wa) begin
      exp_a_q.push_back(fa ? ea : model_read(aa));
      due_a_q.push_back(cyc + 2);
    end
    if (rb && !wb) begin
      exp_b_q.push_back(fb ? eb : model[ab]);
      due_b_q.push_back(cyc + 1);
    end
    if (rb && wb) model[ab] = db;
    if (ra && wa) model_write_a(aa, be, da);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue(0, 0, 11'd0, 4'd0, '0, 0, 0, 9'd0, '0, 0, '0, 0, '0);
  endtask

  task automatic a_rd(input logic [10:0] a, input logic [BW-1:0] e);
    issue(1, 0, a, 4'd0, '0, 0, 0, 9'd0, '0, 1, e, 0, '0);
  endtask

  task automatic a_wr(input logic [10:0] a, input logic [WB-1:0] be, input logic [BW-1:0] d);
    issue(1, 1, a, be, d, 0, 0, 9'd0, '0, 0, '0, 0, '0);
  endtask

  task automatic b_rd(input logic [8:0] a, input logic [BW-1:0] e);
    issue(0, 0, 11'd0, 4'd0, '0, 1, 0, a, '0, 0, '0, 1, e);
  endtask

  task automatic b_wr(input logic [8:0] a, input logic [BW-1:0] d);
    issue(0, 0, 11'd0, 4'd0, '0, 1, 1, a, d, 0, '0, 0, '0);
  endtask

  // --------------------------------------------------------- sequence
  initial begin
    reset = 1'b1;
    requestA = 1'b0; writeEnableA = 1'b0; addressA = '0; byteEnableA = '0; dataInA = '0;
    requestB = 1'b0; writeEnableB = 1'b0; addressB = '0; dataInB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_dataOutA", dataOutA, '0);
    check("reset_validA", 32'(validA), 32'd0);
    check("reset_dataOutB", dataOutB, '0);
    check("reset_validB", 32'(validB), 32'd0);
    reset = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < NE; i++) b_wr(9'(i), $urandom());

    // Unaligned reads, back to back.
    b_wr(9'd0, 32'h11223344);
    b_wr(9'd1, 32'h55667788);
    b_wr(9'd2, 32'h99AABBCC);
    a_rd(11'd1, 32'h22334455);
    a_rd(11'd3, 32'h44556677);
    a_rd(11'd4, 32'h55667788);

    // Unaligned write across words 1 and 2.
    a_wr(11'd6, 4'b1111, 32'hAABBCCDD);
    b_rd(9'd1, 32'h5566AABB);
    b_rd(9'd2, 32'hCCDDBBCC);

    // Partial write: window bytes 1 and 3 only.
    b_wr(9'd0, 32'h11223344);
    b_wr(9'd1, 32'h55667788);
    a_wr(11'd2, 4'b0101, 32'hF1F2F3F4);
    b_rd(9'd0, 32'h112233F2);
    b_rd(9'd1, 32'h55F47788);

    // Window wrapping from the last entry to entry 0.
    b_wr(9'd511, 32'h01020304);
    b_wr(9'd0, 32'hA0B0C0D0);
    a_rd(11'd2046, 32'h0304A0B0);

    // Same-cycle full writes to word 5: port A wins.
    issue(1, 1, 11'd20, 4'b1111, 32'hDEADBEEF, 1, 1, 9'd5, 32'h12345678, 0, '0, 0, '0);
    b_rd(9'd5, 32'hDEADBEEF);
    a_rd(11'd20, 32'hDEADBEEF);

    // B read during an A write to the same word returns the old value.
    issue(1, 1, 11'd20, 4'b1111, 32'h0BADF00D, 1, 0, 9'd5, '0, 0, '0, 1, 32'hDEADBEEF);
    a_rd(11'd20, 32'h0BADF00D);

    // A read during a B write to the same word returns the old value.
    b_wr(9'd6, 32'h13572468);
    issue(1, 0, 11'd24, 4'd0, '0, 1, 1, 9'd6, 32'hCAFEBABE, 1, 32'h13572468, 0, '0);
    b_rd(9'd6, 32'hCAFEBABE);

    // Different bytes of one word from both ports both land.
    issue(1, 1, 11'd28, 4'b1100, 32'hAAAA5555, 1, 1, 9'd7, 32'h11111111, 0, '0, 0, '0);
    b_rd(9'd7, 32'hAAAA1111);
    idle(); idle(); idle();

    // Reset with two A reads in flight and a B write presented under reset.
    requestA = 1'b1; writeEnableA = 1'b0; addressA = 11'd1;
    @(posedge clock); #1;
    addressA = 11'd3; reset = 1'b1;
    requestB = 1'b1; writeEnableB = 1'b1; addressB = 9'd7; dataInB = 32'hFFFFFFFF;
    @(posedge clock); #1;
    reset = 1'b0; requestA = 1'b0; requestB = 1'b0; writeEnableB = 1'b0;
    check("flush_validA_t2", 32'(validA), 32'd0);
    check("flush_dataOutA_t2", dataOutA, '0);
    check("flush_validB_t2", 32'(validB), 32'd0);
    @(posedge clock); #1;
    check("flush_validA_t3", 32'(validA), 32'd0);
    check("flush_dataOutA_t3", dataOutA, '0);
    b_rd(9'd7, 32'hAAAA1111);

    // Random traffic concentrated near word 0 and the wrap point.
    for (int i = 0; i < 400; i++) begin
      logic          ra, wa, rb, wb;
      logic [10:0]   aa;
      logic [8:0]    ab;
      ra = ($urandom_range(0, 9) < 7);
      wa = ($urandom_range(0, 2) == 0);
      aa = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 40)) : 11'($urandom_range(2040, 2047));
      rb = ($urandom_range(0, 9) < 6);
      wb = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 10)) : 9'($urandom_range(508, 511));
      issue(ra, wa, aa, 4'($urandom_range(0, 15)), $urandom(), rb, wb, ab, $urandom(), 0, '0, 0, '0);
    end

    repeat (6) idle();
    check("drain_a", 32'(exp_a_q.size()), 32'd0);
    check("drain_b", 32'(exp_b_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
